// File: rtl/id_ex_register.sv
// ID/EX pipeline register: captures decoded control, operands and register indices for EX,
// with hold (stall), bubble insertion (flush) and a saturating bubble counter.
module id_ex_register #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,

    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_read_data1,
    input  logic [XLEN-1:0]  id_read_data2,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [2:0]       id_funct3,
    input  logic             id_bit30,
    input  logic [1:0]       id_ALU_op,
    input  logic             id_ALUSrc,
    input  logic             id_Branch,
    input  logic             id_MemRead,
    input  logic             id_MemWrite,
    input  logic             id_MemtoReg,
    input  logic             id_RegWrite,

    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_read_data1,
    output logic [XLEN-1:0]  ex_read_data2,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [2:0]       ex_funct3,
    output logic             ex_bit30,
    output logic [1:0]       ex_ALU_op,
    output logic             ex_ALUSrc,
    output logic             ex_Branch,
    output logic             ex_MemRead,
    output logic             ex_MemWrite,
    output logic             ex_MemtoReg,
    output logic             ex_RegWrite,

    output logic [CNT_W-1:0] bubble_count
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] read_data1;
        logic [XLEN-1:0] read_data2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic            bit30;
        logic [1:0]      alu_op;
        logic            alu_src;
        logic            branch;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            reg_write;
    } stage_t;

    stage_t           id_stage;
    stage_t           stage_q, stage_d;
    logic [CNT_W-1:0] bubble_count_q, bubble_count_d;

    always_comb begin
        id_stage.valid      = id_valid;
        id_stage.pc         = id_pc;
        id_stage.read_data1 = id_read_data1;
        id_stage.read_data2 = id_read_data2;
        id_stage.imm        = id_imm;
        id_stage.rs1        = id_rs1;
        id_stage.rs2        = id_rs2;
        id_stage.rd         = id_rd;
        id_stage.funct3     = id_funct3;
        id_stage.bit30      = id_bit30;
        id_stage.alu_op     = id_ALU_op;
        id_stage.alu_src    = id_ALUSrc;
        id_stage.branch     = id_Branch;
        id_stage.mem_read   = id_MemRead;
        id_stage.mem_write  = id_MemWrite;
        id_stage.mem_to_reg = id_MemtoReg;
        id_stage.reg_write  = id_RegWrite;
    end

    // An all-zero stage is a NOP for EX (ALU_op 00, no control asserted), so a bubble is '0.
    always_comb begin
        stage_d        = stage_q;
        bubble_count_d = bubble_count_q;
        if (flush) begin
            stage_d = '0;
            if (!(&bubble_count_q)) begin
                bubble_count_d = bubble_count_q + CNT_W'(1);
            end
        end else if (!stall) begin
            stage_d = id_stage;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q        <= '0;
            bubble_count_q <= '0;
        end else begin
            stage_q        <= stage_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign ex_valid      = stage_q.valid;
    assign ex_pc         = stage_q.pc;
    assign ex_read_data1 = stage_q.read_data1;
    assign ex_read_data2 = stage_q.read_data2;
    assign ex_imm        = stage_q.imm;
    assign ex_rs1        = stage_q.rs1;
    assign ex_rs2        = stage_q.rs2;
    assign ex_rd         = stage_q.rd;
    assign ex_funct3     = stage_q.funct3;
    assign ex_bit30      = stage_q.bit30;
    assign ex_ALU_op     = stage_q.alu_op;
    assign ex_ALUSrc     = stage_q.alu_src;
    assign ex_Branch     = stage_q.branch;
    assign ex_MemRead    = stage_q.mem_read;
    assign ex_MemWrite   = stage_q.mem_write;
    assign ex_MemtoReg   = stage_q.mem_to_reg;
    assign ex_RegWrite   = stage_q.reg_write;
    assign bubble_count  = bubble_count_q;

endmodule
